mod_mem_arbiter: RTL and testbench

- Sits directly downstream of the L1 instruction and data caches and arbitrates their single-line requests onto the 64-bit system bus.
- Converts 512-bit cache-line writes into address+8 data beats.
- Assembles 8 read-response beats into one line.
- Generates write-completion responses back to the requesting cache.

---
 rtl/mod_mem_arbiter_if.sv | 55 +++++
 rtl/mod_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mod_mem_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_mem_arbiter_if.sv
// rtl/mod_mem_arbiter_if.sv - cache request/response and system bus signal bundle for mod_mem_arbiter
interface mod_mem_arbiter_if #(
    parameter int ADDRSIZE = 64,
    parameter int WORDSIZE = 64,
    parameter int LINEBITS = 512,
    parameter int TAGWIDTH = 13
);
    logic                d_reqcyc;
    logic                d_reqack;
    logic [ADDRSIZE-1:0] d_req;
    logic [TAGWIDTH-1:0] d_reqtag;
    logic [LINEBITS-1:0] d_reqdata;
    logic                d_respcyc;
    logic                d_respack;
    logic [LINEBITS-1:0] d_resp;
    logic [TAGWIDTH-1:0] d_resptag;

    logic                i_reqcyc;
    logic                i_reqack;
    logic [ADDRSIZE-1:0] i_req;
    logic [TAGWIDTH-1:0] i_reqtag;
    logic [LINEBITS-1:0] i_reqdata;
    logic                i_respcyc;
    logic                i_respack;
    logic [LINEBITS-1:0] i_resp;
    logic [TAGWIDTH-1:0] i_resptag;

    logic                bus_reqcyc;
    logic                bus_reqack;
    logic [WORDSIZE-1:0] bus_req;
    logic [TAGWIDTH-1:0] bus_reqtag;
    logic                bus_respcyc;
    logic                bus_respack;
    logic [WORDSIZE-1:0] bus_resp;
    logic [TAGWIDTH-1:0] bus_resptag;

    // Arbiter side: accepts cache requests, drives the system bus.
    modport slave (
        input  d_reqcyc, d_req, d_reqtag, d_reqdata, d_respack,
        input  i_reqcyc, i_req, i_reqtag, i_reqdata, i_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output d_reqack, d_respcyc, d_resp, d_resptag,
        output i_reqack, i_respcyc, i_resp, i_resptag,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport master (
        output d_reqcyc, d_req, d_reqtag, d_reqdata, d_respack,
        output i_reqcyc, i_req, i_reqtag, i_reqdata, i_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  d_reqack, d_respcyc, d_resp, d_resptag,
        input  i_reqack, i_respcyc, i_resp, i_resptag,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/mod_mem_arbiter.sv
// rtl/mod_mem_arbiter.sv - round-robin I/D cache line arbiter onto the 64-bit system bus
module mod_mem_arbiter #(
    parameter int ADDRSIZE = 64,
    parameter int WORDSIZE = 64,
    parameter int LINEBITS = 512,
    parameter int TAGWIDTH = 13
) (
    input logic              clk,
    input logic              reset,
    mod_mem_arbiter_if.slave arb
);
    localparam int BEATS = LINEBITS / WORDSIZE;
    localparam int CNTW  = $clog2(BEATS);
    localparam int OFFW  = $clog2(LINEBITS / 8);
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_RESP
    } state_e;

    state_e                   state_q, state_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic                     src_q, src_d;    // 1 = I-cache owns the transaction
    logic                     prio_q, prio_d;  // tie winner, 1 = I-cache
    logic [ADDRSIZE-OFFW-1:0] addr_q, addr_d;
    logic [TAGWIDTH-1:0]      tag_q, tag_d;
    logic [LINEBITS-1:0]      line_q, line_d;
    logic                     d_ack_q, d_ack_d;
    logic                     i_ack_q, i_ack_d;

    logic grant_i;
    logic resp_accept;
    logic is_read;
    logic unused_bits;

    assign grant_i     = arb.i_reqcyc && (!arb.d_reqcyc || prio_q);
    assign resp_accept = src_q ? arb.i_respack : arb.d_respack;
    assign is_read     = tag_q[TAGWIDTH-1];

    // Read beats arriving outside RDATA are acknowledged and dropped.
    assign arb.bus_respack = arb.bus_respcyc;

    assign unused_bits = ^{arb.bus_resptag, arb.d_req[OFFW-1:0], arb.i_req[OFFW-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        line_d  = line_q;
        d_ack_d = 1'b0;
        i_ack_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb.d_reqcyc || arb.i_reqcyc) begin
                    src_d   = grant_i;
                    addr_d  = grant_i ? arb.i_req[ADDRSIZE-1:OFFW] : arb.d_req[ADDRSIZE-1:OFFW];
                    tag_d   = grant_i ? arb.i_reqtag : arb.d_reqtag;
                    line_d  = grant_i ? arb.i_reqdata : arb.d_reqdata;
                    d_ack_d = !grant_i;
                    i_ack_d = grant_i;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arb.bus_reqack) begin
                    cnt_d   = '0;
                    state_d = is_read ? S_RDATA : S_WDATA;
                end
            end
            S_WDATA: begin
                if (arb.bus_reqack) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            S_RDATA: begin
                if (arb.bus_respcyc) begin
                    line_d[int'(cnt_q)*WORDSIZE +: WORDSIZE] = arb.bus_resp;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (resp_accept) begin
                    prio_d  = !src_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
            line_q  <= '0;
            d_ack_q <= 1'b0;
            i_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
            d_ack_q <= d_ack_d;
            i_ack_q <= i_ack_d;
        end
    end

    // Every output decodes from registered state, so reset clears them all at once.
    always_comb begin
        arb.bus_reqcyc = 1'b0;
        arb.bus_req    = '0;
        arb.bus_reqtag = '0;
        arb.d_reqack   = d_ack_q;
        arb.i_reqack   = i_ack_q;
        arb.d_respcyc  = 1'b0;
        arb.d_resp     = '0;
        arb.d_resptag  = '0;
        arb.i_respcyc  = 1'b0;
        arb.i_resp     = '0;
        arb.i_resptag  = '0;

        case (state_q)
            S_ADDR: begin
                arb.bus_reqcyc = 1'b1;
                arb.bus_req    = WORDSIZE'({addr_q, {OFFW{1'b0}}});
                arb.bus_reqtag = tag_q;
            end
            S_WDATA: begin
                arb.bus_reqcyc = 1'b1;
                arb.bus_req    = line_q[int'(cnt_q)*WORDSIZE +: WORDSIZE];
                arb.bus_reqtag = tag_q;
            end
            S_RESP: begin
                if (src_q) begin
                    arb.i_respcyc = 1'b1;
                    arb.i_resptag = tag_q;
                    arb.i_resp    = is_read ? line_q : '0;
                end else begin
                    arb.d_respcyc = 1'b1;
                    arb.d_resptag = tag_q;
                    arb.d_resp    = is_read ? line_q : '0;
                end
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_mod_mem_arbiter.sv
// tb/tb_mod_mem_arbiter.sv - directed self-checking bench for mod_mem_arbiter
module tb_mod_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mod_mem_arbiter_if ifc ();

    mod_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .arb   (ifc)
    );

    always #5 clk = ~clk;

    // Observations gathered by the driver tasks; side index 0 = D, 1 = I.
    logic [63:0]  bus_beats [0:8];
    int           bus_nb;
    bit           bus_stable;
    bit           bus_to;
    time          t_first_beat;
    time          t_last_beat;
    logic [511:0] rsp_line  [0:1];
    logic [12:0]  rsp_tag   [0:1];
    bit           rsp_stable[0:1];
    bit           rsp_to    [0:1];
    bit           rsp_drop  [0:1];
    time          t_resp    [0:1];
    bit           req_to    [0:1];
    time          t_ack     [0:1];

    int d_ack_n, i_ack_n, d_resp_n, i_resp_n, clash_n;
    int grant_q[$];

    always @(negedge clk) begin
        if (ifc.d_reqack === 1'b1) begin d_ack_n++; grant_q.push_back(0); end
        if (ifc.i_reqack === 1'b1) begin i_ack_n++; grant_q.push_back(1); end
        if (ifc.d_respcyc === 1'b1) d_resp_n++;
        if (ifc.i_respcyc === 1'b1) i_resp_n++;
        if ((ifc.d_reqack && ifc.i_reqack) || (ifc.d_respcyc && ifc.i_respcyc)) clash_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        d_ack_n = 0; i_ack_n = 0; d_resp_n = 0; i_resp_n = 0; clash_n = 0;
        grant_q.delete();
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
        return l;
    endfunction

    function automatic logic any_out();
        return |{ifc.d_reqack, ifc.d_respcyc, ifc.d_resp, ifc.d_resptag,
                 ifc.i_reqack, ifc.i_respcyc, ifc.i_resp, ifc.i_resptag,
                 ifc.bus_reqcyc, ifc.bus_req, ifc.bus_reqtag};
    endfunction

    function automatic logic rc(input int s);
        return (s == 0) ? ifc.d_respcyc : ifc.i_respcyc;
    endfunction

    task automatic cache_req(input int s, input logic [63:0] a, input logic [12:0] t,
                             input logic [511:0] dat);
        int n;
        n = 0;
        if (s == 0) begin
            ifc.d_reqcyc = 1'b1; ifc.d_req = a; ifc.d_reqtag = t; ifc.d_reqdata = dat;
        end else begin
            ifc.i_reqcyc = 1'b1; ifc.i_req = a; ifc.i_reqtag = t; ifc.i_reqdata = dat;
        end
        while (((s == 0) ? ifc.d_reqack : ifc.i_reqack) !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        req_to[s] = (((s == 0) ? ifc.d_reqack : ifc.i_reqack) !== 1'b1);
        t_ack[s] = $time;
        if (s == 0) ifc.d_reqcyc = 1'b0;
        else        ifc.i_reqcyc = 1'b0;
    endtask

    task automatic cache_resp(input int s, input int hold);
        int n;
        n = 0;
        rsp_to[s] = 1'b0; rsp_stable[s] = 1'b1; rsp_drop[s] = 1'b0;
        while (rc(s) !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (rc(s) !== 1'b1) begin
            rsp_to[s] = 1'b1;
            return;
        end
        t_resp[s]   = $time;
        rsp_line[s] = (s == 0) ? ifc.d_resp : ifc.i_resp;
        rsp_tag[s]  = (s == 0) ? ifc.d_resptag : ifc.i_resptag;
        for (int h = 0; h < hold; h++) begin
            step();
            if (rc(s) !== 1'b1 || ((s == 0) ? ifc.d_resp : ifc.i_resp) !== rsp_line[s])
                rsp_stable[s] = 1'b0;
        end
        if (s == 0) ifc.d_respack = 1'b1;
        else        ifc.i_respack = 1'b1;
        step();
        ifc.d_respack = 1'b0;
        ifc.i_respack = 1'b0;
        rsp_drop[s] = (rc(s) === 1'b0);
    endtask

    task automatic bus_slave(input int stall_at, input int stall_n, input logic [63:0] rd_base);
        int n;
        int total;
        logic [63:0] hold;
        n = 0; bus_nb = 0; bus_stable = 1'b1; bus_to = 1'b0;
        while (ifc.bus_reqcyc !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (ifc.bus_reqcyc !== 1'b1) begin
            bus_to = 1'b1;
            return;
        end
        t_first_beat = $time;
        total = (ifc.bus_reqtag[12] === 1'b1) ? 1 : 9;
        while (bus_nb < total) begin
            if (ifc.bus_reqcyc !== 1'b1) begin
                bus_to = 1'b1;
                return;
            end
            if (bus_nb == stall_at) begin
                hold = ifc.bus_req;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    if (ifc.bus_reqcyc !== 1'b1 || ifc.bus_req !== hold) bus_stable = 1'b0;
                end
            end
            bus_beats[bus_nb] = ifc.bus_req;
            ifc.bus_reqack = 1'b1;
            t_last_beat = $time;
            step();
            ifc.bus_reqack = 1'b0;
            bus_nb++;
        end
        if (total == 1) begin
            for (int k = 0; k < 8; k++) begin
                ifc.bus_respcyc = 1'b1;
                ifc.bus_resp = rd_base + 64'(k);
                t_last_beat = $time;
                step();
            end
            ifc.bus_respcyc = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_mon();
        reset = 1'b0;
        ifc.d_reqcyc = 1'b1; ifc.i_reqcyc = 1'b1; ifc.bus_respcyc = 1'b1;
        repeat (3) step();
        checks++;
        if (any_out() !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 0", any_out());
        end
        checks++;
        if (ifc.bus_respack !== 1'b1) begin
            errors++; $display("FAIL reset_respack_high got %b want 1", ifc.bus_respack);
        end
        checks++;
        if (d_ack_n + i_ack_n !== 0) begin
            errors++; $display("FAIL reset_no_grant got %0d want 0", d_ack_n + i_ack_n);
        end
        ifc.bus_respcyc = 1'b0;
        #1;
        checks++;
        if (ifc.bus_respack !== 1'b0) begin
            errors++; $display("FAIL reset_respack_low got %b want 0", ifc.bus_respack);
        end
        ifc.d_reqcyc = 1'b0; ifc.i_reqcyc = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++;
        if (any_out() !== 1'b0) begin
            errors++; $display("FAIL reset_idle_after_release got %b want 0", any_out());
        end
    endtask

    task automatic test_d_read();
        clear_mon();
        fork
            cache_req(0, 64'h1040, 13'h1005, '0);
            bus_slave(-1, 0, 64'h0);
            cache_resp(0, 0);
        join
        checks++;
        if ({req_to[0], bus_to, rsp_to[0]} !== 3'b000) begin
            errors++; $display("FAIL rd_timeout got %b want 000", {req_to[0], bus_to, rsp_to[0]});
        end
        checks++;
        if (bus_nb !== 1 || bus_beats[0] !== 64'h1040) begin
            errors++; $display("FAIL rd_addr_beat got %0d/%h want 1/1040", bus_nb, bus_beats[0]);
        end
        checks++;
        if (rsp_line[0] !== mk_line(64'h0)) begin
            errors++; $display("FAIL rd_line got %h want %h", rsp_line[0], mk_line(64'h0));
        end
        checks++;
        if (rsp_tag[0] !== 13'h1005) begin
            errors++; $display("FAIL rd_tag got %h want 1005", rsp_tag[0]);
        end
        checks++;
        if (d_resp_n !== 1 || d_ack_n !== 1 || i_ack_n !== 0) begin
            errors++; $display("FAIL rd_pulses got %0d/%0d/%0d want 1/1/0", d_resp_n, d_ack_n, i_ack_n);
        end
        checks++;
        if (t_first_beat !== t_ack[0]) begin
            errors++; $display("FAIL rd_grant_latency got %0t want %0t", t_first_beat, t_ack[0]);
        end
        checks++;
        if (t_resp[0] !== t_last_beat + 10) begin
            errors++; $display("FAIL rd_resp_latency got %0t want %0t", t_resp[0], t_last_beat + 10);
        end
    endtask

    task automatic test_d_write();
        clear_mon();
        fork
            cache_req(0, 64'h207F, 13'h00A5, mk_line(64'hA0));
            bus_slave(4, 2, 64'h0);
            cache_resp(0, 0);
        join
        checks++;
        if ({req_to[0], bus_to, rsp_to[0]} !== 3'b000) begin
            errors++; $display("FAIL wr_timeout got %b want 000", {req_to[0], bus_to, rsp_to[0]});
        end
        checks++;
        if (bus_nb !== 9 || bus_beats[0] !== 64'h2040) begin
            errors++; $display("FAIL wr_addr_beat got %0d/%h want 9/2040", bus_nb, bus_beats[0]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus_beats[k+1] !== 64'hA0 + 64'(k)) begin
                errors++; $display("FAIL wr_beat%0d got %h want %h", k, bus_beats[k+1], 64'hA0 + 64'(k));
            end
        end
        checks++;
        if (bus_stable !== 1'b1) begin
            errors++; $display("FAIL wr_stall_stable got %b want 1", bus_stable);
        end
        checks++;
        if (rsp_tag[0] !== 13'h00A5 || rsp_line[0] !== '0) begin
            errors++; $display("FAIL wr_resp got %h/%h want 00a5/0", rsp_tag[0], rsp_line[0]);
        end
        checks++;
        if (t_resp[0] !== t_last_beat + 10) begin
            errors++; $display("FAIL wr_resp_latency got %0t want %0t", t_resp[0], t_last_beat + 10);
        end
    endtask

    task automatic test_arbitration();
        int g0, g1;
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_mon();
        fork
            cache_req(0, 64'h4000, 13'h1001, '0);
            cache_req(1, 64'h5000, 13'h1002, '0);
            begin bus_slave(-1, 0, 64'h100); bus_slave(-1, 0, 64'h200); end
            cache_resp(0, 0);
            cache_resp(1, 0);
        join
        g0 = (grant_q.size() > 0) ? grant_q[0] : -1;
        g1 = (grant_q.size() > 1) ? grant_q[1] : -1;
        checks++;
        if (grant_q.size() !== 2 || g0 !== 0 || g1 !== 1) begin
            errors++; $display("FAIL arb_pair1_order got %0d:%0d,%0d want 2:0,1", grant_q.size(), g0, g1);
        end
        checks++;
        if (rsp_line[0] !== mk_line(64'h100) || rsp_line[1] !== mk_line(64'h200)) begin
            errors++; $display("FAIL arb_pair1_data got %h/%h want base 100/200", rsp_line[0][63:0], rsp_line[1][63:0]);
        end
        fork
            cache_req(0, 64'h4040, 13'h1003, '0);
            bus_slave(-1, 0, 64'h300);
            cache_resp(0, 0);
        join
        clear_mon();
        fork
            cache_req(0, 64'h4080, 13'h1004, '0);
            cache_req(1, 64'h5080, 13'h1006, '0);
            begin bus_slave(-1, 0, 64'h400); bus_slave(-1, 0, 64'h500); end
            cache_resp(0, 0);
            cache_resp(1, 0);
        join
        g0 = (grant_q.size() > 0) ? grant_q[0] : -1;
        g1 = (grant_q.size() > 1) ? grant_q[1] : -1;
        checks++;
        if (grant_q.size() !== 2 || g0 !== 1 || g1 !== 0) begin
            errors++; $display("FAIL arb_pair2_order got %0d:%0d,%0d want 2:1,0", grant_q.size(), g0, g1);
        end
        checks++;
        if (rsp_line[1] !== mk_line(64'h400) || rsp_tag[0] !== 13'h1004 || rsp_line[0] !== mk_line(64'h500)) begin
            errors++; $display("FAIL arb_pair2_data got %h/%h/%h want 400/1004/500", rsp_line[1][63:0], rsp_tag[0], rsp_line[0][63:0]);
        end
        checks++;
        if (clash_n !== 0) begin
            errors++; $display("FAIL arb_no_clash got %0d want 0", clash_n);
        end
    endtask

    task automatic test_reset_midburst();
        int n;
        clear_mon();
        n = 0;
        ifc.d_reqcyc = 1'b1; ifc.d_req = 64'h3000; ifc.d_reqtag = 13'h1111; ifc.d_reqdata = '0;
        while (ifc.bus_reqcyc !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (ifc.bus_reqcyc !== 1'b1) begin
            errors++; $display("FAIL rst_mid_addr got %b want 1", ifc.bus_reqcyc);
        end
        ifc.d_reqcyc = 1'b0;
        ifc.bus_reqack = 1'b1;
        step();
        ifc.bus_reqack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifc.bus_respcyc = 1'b1; ifc.bus_resp = 64'(k);
            step();
        end
        ifc.bus_respcyc = 1'b1; ifc.bus_resp = 64'h4;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (any_out() !== 1'b0 || ifc.bus_respack !== 1'b1) begin
            errors++; $display("FAIL rst_mid_outputs got %b/%b want 0/1", any_out(), ifc.bus_respack);
        end
        ifc.bus_respcyc = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (12) step();
        checks++;
        if (d_resp_n !== 0 || i_resp_n !== 0) begin
            errors++; $display("FAIL rst_mid_no_resp got %0d/%0d want 0/0", d_resp_n, i_resp_n);
        end
        fork
            cache_req(1, 64'h6000, 13'h1ABC, '0);
            bus_slave(-1, 0, 64'h600);
            cache_resp(1, 0);
        join
        checks++;
        if (rsp_to[1] !== 1'b0 || rsp_line[1] !== mk_line(64'h600) || rsp_tag[1] !== 13'h1ABC) begin
            errors++; $display("FAIL rst_mid_i_read got %b/%h/%h want 0/600/1abc", rsp_to[1], rsp_line[1][63:0], rsp_tag[1]);
        end
    endtask

    task automatic test_resp_stall();
        clear_mon();
        fork
            cache_req(0, 64'h7000, 13'h1234, '0);
            bus_slave(-1, 0, 64'h700);
            cache_resp(0, 3);
        join
        checks++;
        if (rsp_stable[0] !== 1'b1 || rsp_line[0] !== mk_line(64'h700)) begin
            errors++; $display("FAIL stall_resp_stable got %b/%h want 1/700", rsp_stable[0], rsp_line[0][63:0]);
        end
        checks++;
        if (d_resp_n !== 4) begin
            errors++; $display("FAIL stall_resp_cycles got %0d want 4", d_resp_n);
        end
        checks++;
        if (rsp_drop[0] !== 1'b1 || ifc.bus_reqcyc !== 1'b0) begin
            errors++; $display("FAIL stall_back_to_idle got %b/%b want 1/0", rsp_drop[0], ifc.bus_reqcyc);
        end
    endtask

    task automatic test_stray();
        clear_mon();
        ifc.bus_respcyc = 1'b1; ifc.bus_resp = 64'hDEAD;
        #1;
        checks++;
        if (ifc.bus_respack !== 1'b1) begin
            errors++; $display("FAIL stray_respack got %b want 1", ifc.bus_respack);
        end
        step();
        ifc.bus_respcyc = 1'b0;
        repeat (3) step();
        checks++;
        if (d_resp_n !== 0 || i_resp_n !== 0 || ifc.bus_reqcyc !== 1'b0) begin
            errors++; $display("FAIL stray_no_effect got %0d/%0d/%b want 0/0/0", d_resp_n, i_resp_n, ifc.bus_reqcyc);
        end
        fork
            cache_req(0, 64'h8000, 13'h1777, '0);
            bus_slave(-1, 0, 64'h800);
            cache_resp(0, 0);
        join
        checks++;
        if (rsp_line[0] !== mk_line(64'h800)) begin
            errors++; $display("FAIL stray_next_read got %h want %h", rsp_line[0], mk_line(64'h800));
        end
    endtask

    initial begin
        reset = 1'b0;
        ifc.d_reqcyc = 1'b0; ifc.d_req = '0; ifc.d_reqtag = '0; ifc.d_reqdata = '0; ifc.d_respack = 1'b0;
        ifc.i_reqcyc = 1'b0; ifc.i_req = '0; ifc.i_reqtag = '0; ifc.i_reqdata = '0; ifc.i_respack = 1'b0;
        ifc.bus_reqack = 1'b0; ifc.bus_respcyc = 1'b0; ifc.bus_resp = '0; ifc.bus_resptag = '0;
        test_reset();
        test_d_read();
        test_d_write();
        test_arbitration();
        test_reset_midburst();
        test_resp_stall();
        test_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
